rf_wb_scheduler: RTL

- Sequences the single write port of the register file: arbitrates writeback requests from several execution units (ALU, load unit, mul/div) round-robin, one write per cycle.
- Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards against outstanding multi-cycle producers.
- Sits between the execute/writeback units and the register file write port (rf_wr_en, rd_addr, wr_data).

---
 rtl/rf_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/rf_wb_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/rf_sched_pkg.sv
// Shared defaults and requester indices for the register-file writeback scheduler.
package rf_sched_pkg;

  localparam int RF_XLEN    = 32;
  localparam int RF_AW      = 5;
  localparam int RF_NUM_REQ = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk the N candidate slots starting at ptr; the first requester found wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write port sequencer: round-robin writeback arbitration, a registered
// commit stage and a per-register busy scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int XLEN    = RF_XLEN,
  parameter int AW      = RF_AW
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic [NUM_REQ-1:0]      wb_valid,
  input  logic [NUM_REQ*AW-1:0]   wb_rd,
  input  logic [NUM_REQ*XLEN-1:0] wb_data,
  output logic [NUM_REQ-1:0]      wb_ready,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  input  logic [AW-1:0]           iss_rs1,
  input  logic [AW-1:0]           iss_rs2,
  input  logic                    iss_wr,
  output logic                    iss_stall,
  output logic                    rf_wr_en,
  output logic [AW-1:0]           rd_addr,
  output logic [XLEN-1:0]         wr_data
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_valid;
  logic               grant;
  logic [AW-1:0]      sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_set;
  logic [NREG-1:0]    busy_clr;
  logic [NREG-1:0]    busy_nxt;
  logic               iss_accept;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req       (wb_valid),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Grants are suppressed while in reset so a pending request is never consumed.
  assign grant    = res_n && arb_valid;
  assign wb_ready = res_n ? arb_gnt : '0;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_rd   = wb_rd[i*AW +: AW];
        sel_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  assign iss_stall  = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || (iss_wr && busy[iss_rd]));
  assign iss_accept = iss_valid && !iss_stall && iss_wr && (iss_rd != '0);

  // Set is applied after clear so a same-edge issue of the committing register stays busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_accept) begin
      busy_set[iss_rd] = 1'b1;
    end
    if (grant && (sel_rd != '0)) begin
      busy_clr[sel_rd] = 1'b1;
    end
    busy_nxt = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      busy     <= '0;
      rr_ptr   <= '0;
      rf_wr_en <= 1'b0;
      rd_addr  <= '0;
      wr_data  <= '0;
    end else begin
      busy     <= busy_nxt;
      rf_wr_en <= grant && (sel_rd != '0);
      if (grant) begin
        rr_ptr  <= (arb_idx == PW'(NUM_REQ-1)) ? '0 : arb_idx + PW'(1);
        rd_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

endmodule
